trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
Parametrised machine-mode trap controller at the writeback boundary of the 5-stage pipeline. It arbitrates synchronous exceptions, mret and NUM_IRQ prioritised interrupt lines. It owns mstatus.MIE/MPIE, mie, mip, mtvec, mepc and mcause. On a taken trap or return it emits a one-cycle flush/redirect, then a one-cycle hold-off.

Parameters:
XLEN, 32, datapath/CSR width
NUM_IRQ, 8, interrupt lines (1..16)
IRQ_EDGE_MASK, 0, bit i=1: line i edge-triggered (latched); 0: level
IRQ_CAUSE_BASE, 16, exception code of line 0 (line i -> BASE+i)
RESET_MTVEC, 0, mtvec reset value

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_wb_valid  in  1  valid instruction in WB
wb_pc  in  XLEN  PC of WB instruction
exception_req  in  1  WB instruction raised exception
exception_cause  in  XLEN  exception code (bit XLEN-1 must be 0)
mret_req  in  1  WB instruction is mret
irq_in  in  NUM_IRQ  raw interrupt lines
csr_we  in  1  CSR write strobe
csr_sel  in  2  0=mstatus, 1=mie, 2=mtvec, 3=ignored
csr_wdata  in  XLEN  write data
flush  out  1  one-cycle pipeline flush
redirect_pc  out  XLEN  fetch target, valid with flush
trap_taken  out  1  one-cycle pulse, trap entry
mret_taken  out  1  one-cycle pulse, return
trap_cause  out  XLEN  mcause value of the current entry
mepc  out  XLEN  saved PC
mcause  out  XLEN  saved cause
mtvec  out  XLEN  trap vector
mstatus_mie  out  1  global interrupt enable
mie  out  NUM_IRQ  per-line enable
mip  out  NUM_IRQ  pending lines
busy  out  1  high in ENTER/HOLD

Behaviour:
- Reset: all outputs and registers 0, except mtvec=RESET_MTVEC. irq_q (edge history)=0, state=IDLE. Reset mid-ENTER/HOLD aborts to IDLE with no flush.
- Pending:
  - Level line i: mip[i]=irq_in[i].
  - Edge line i: set on irq_in[i] & ~irq_q[i]; cleared when line i is taken. Set wins over same-cycle clear.
  - irq_q registered every cycle.
- Request evaluation happens in IDLE only, with mem_wb_valid=1. Priority: exception > mret > interrupt.
  - Interrupt candidate: lowest index i with mip[i]&mie[i], and only if mstatus_mie=1.
  - Exceptions ignore MIE.
- Trap accept (registered, effective next cycle = ENTER):
  - mepc<=wb_pc
  - mcause<=exception_cause, or for an interrupt {1'b1, code=IRQ_CAUSE_BASE+i}
  - MPIE<=MIE, MIE<=0
- mret accept: MIE<=MPIE, MPIE<=1.
- ENTER (1 cycle):
  - flush=1
  - trap: trap_taken=1, trap_cause=mcause. redirect_pc = {mtvec[XLEN-1:2],2'b00}; if mtvec[1:0]==1 and the trap is an interrupt, add 4*code.
  - mret: mret_taken=1, redirect_pc=mepc.
  - Then HOLD.
- HOLD (1 cycle): no accept; then IDLE. Minimum spacing between flushes is 3 cycles.
- CSR writes:
  - mstatus: bit3=MIE, bit7=MPIE.
  - mie: bits[NUM_IRQ-1:0].
  - mtvec: full word; mode values 2/3 are treated as 0.
  - Reads are via the outputs. mstatus read value is MIE at bit3, MPIE at bit7.
  - Same-cycle trap/mret accept overrides a csr mstatus write. mie/mtvec writes still apply.
  - A write in ENTER/HOLD applies normally.
- A CSR write enabling MIE takes effect for accept one cycle later (registered).
- mem_wb_valid=0: nothing accepted; edge pendings are retained.

Test Plan:
- Reset, then mie=0xFF, MIE=1; pulse edge line 3 for 1 cycle with mem_wb_valid=1, wb_pc=0x100 -> ENTER: flush=1, mcause=0x80000013, mepc=0x100, redirect_pc=mtvec base, MIE=0, MPIE=1, mip[3] cleared; busy high 2 cycles.
- Vectored mode: mtvec=0x201, line 0 → redirect_pc=0x200+4*16=0x240.
- exception_req (cause 0xB) in the same cycle as pending enabled line 2 → mcause=0xB, line 2 stays pending. After mret (MIE restored=1) plus the HOLD cycle, line 2 is taken with mcause=0x80000012.
- mret with mepc=0x400, MPIE=1 → flush, mret_taken=1, redirect_pc=0x400, MIE=1, MPIE=1.
- MIE=0 with level line 5 high: no trap. csr write mstatus=0x8 → trap on the following cycle. An exception while MIE=0 is still taken.
- Request during HOLD is ignored and taken on the first IDLE cycle. Rst asserted during ENTER → flush drops next cycle, all registers return to reset values.

Source files
------------

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller at the writeback boundary.
// Arbitrates exceptions, mret and prioritised interrupts; owns the trap CSRs.
module trap_ctrl #(
   parameter int               XLEN           = 32,
   parameter int               NUM_IRQ        = 8,
   parameter logic [15:0]      IRQ_EDGE_MASK  = '0,
   parameter int               IRQ_CAUSE_BASE = 16,
   parameter logic [XLEN-1:0]  RESET_MTVEC    = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_wb_valid,
   input  logic [XLEN-1:0]    wb_pc,
   input  logic               exception_req,
   input  logic [XLEN-1:0]    exception_cause,
   input  logic               mret_req,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               csr_we,
   input  logic [1:0]         csr_sel,
   input  logic [XLEN-1:0]    csr_wdata,
   output logic               flush,
   output logic [XLEN-1:0]    redirect_pc,
   output logic               trap_taken,
   output logic               mret_taken,
   output logic [XLEN-1:0]    trap_cause,
   output logic [XLEN-1:0]    mepc,
   output logic [XLEN-1:0]    mcause,
   output logic [XLEN-1:0]    mtvec,
   output logic               mstatus_mie,
   output logic [NUM_IRQ-1:0] mie,
   output logic [NUM_IRQ-1:0] mip,
   output logic               busy
);

   localparam logic [NUM_IRQ-1:0] EDGE = IRQ_EDGE_MASK[NUM_IRQ-1:0];

   typedef enum logic [1:0] {IDLE, ENTER, HOLD} state_t;

   state_t              state;
   logic                mpie;
   logic [NUM_IRQ-1:0]  irq_q;
   logic [NUM_IRQ-1:0]  edge_pend;
   logic [NUM_IRQ-1:0]  irq_act;
   logic [NUM_IRQ-1:0]  irq_oh;
   logic [3:0]          irq_idx;
   logic [XLEN-1:0]     irq_cause;
   logic [XLEN-1:0]     vec_base;
   logic                can_accept;
   logic                take_exc;
   logic                take_mret;
   logic                take_irq;

   assign mip     = (irq_in & ~EDGE) | (edge_pend & EDGE);
   assign irq_act = mip & mie;
   assign busy    = (state != IDLE);

   // Lowest index wins: scan downward so the last hit is the smallest.
   always_comb begin
      irq_idx = '0;
      irq_oh  = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq_act[i]) begin
            irq_idx   = 4'(i);
            irq_oh    = '0;
            irq_oh[i] = 1'b1;
         end
      end
   end

   assign irq_cause = {1'b1, (XLEN-1)'(IRQ_CAUSE_BASE) + (XLEN-1)'(irq_idx)};

   assign can_accept = (state == IDLE) && mem_wb_valid;
   assign take_exc   = can_accept && exception_req;
   assign take_mret  = can_accept && !exception_req && mret_req;
   assign take_irq   = can_accept && !exception_req && !mret_req
                       && mstatus_mie && (|irq_act);

   assign vec_base = {mtvec[XLEN-1:2], 2'b00};

   always_comb begin
      redirect_pc = '0;
      trap_cause  = '0;
      if (trap_taken) begin
         trap_cause  = mcause;
         redirect_pc = vec_base;
         if (mtvec[1:0] == 2'b01 && mcause[XLEN-1])
            redirect_pc = vec_base + {mcause[XLEN-3:0], 2'b00};
      end else if (mret_taken) begin
         redirect_pc = mepc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         flush       <= 1'b0;
         trap_taken  <= 1'b0;
         mret_taken  <= 1'b0;
         mepc        <= '0;
         mcause      <= '0;
         mtvec       <= RESET_MTVEC;
         mstatus_mie <= 1'b0;
         mpie        <= 1'b0;
         mie         <= '0;
         irq_q       <= '0;
         edge_pend   <= '0;
      end else begin
         irq_q      <= irq_in;
         edge_pend  <= ((edge_pend & ~(take_irq ? irq_oh : '0))
                        | (irq_in & ~irq_q)) & EDGE;
         flush      <= 1'b0;
         trap_taken <= 1'b0;
         mret_taken <= 1'b0;

         if (csr_we) begin
            case (csr_sel)
               2'd0: begin
                  mstatus_mie <= csr_wdata[3];
                  mpie        <= csr_wdata[7];
               end
               2'd1:    mie   <= csr_wdata[NUM_IRQ-1:0];
               2'd2:    mtvec <= csr_wdata;
               default: ;
            endcase
         end

         // Accept-side updates come last so they override an mstatus write.
         unique case (state)
            IDLE: begin
               if (take_exc || take_irq) begin
                  mepc        <= wb_pc;
                  mcause      <= take_exc ? exception_cause : irq_cause;
                  mpie        <= mstatus_mie;
                  mstatus_mie <= 1'b0;
                  flush       <= 1'b1;
                  trap_taken  <= 1'b1;
                  state       <= ENTER;
               end else if (take_mret) begin
                  mstatus_mie <= mpie;
                  mpie        <= 1'b1;
                  flush       <= 1'b1;
                  mret_taken  <= 1'b1;
                  state       <= ENTER;
               end
            end
            ENTER:   state <= HOLD;
            HOLD:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
